// File: rtl/lbr_pkg.sv
// lbr_pkg: shared encodings and status-word layout for the last branch record unit
// Contents:
//   lbr_req_e  - lbrReq encodings (none / read FROM / read TO / read status)
//   npc_sel_e  - next_PC_sel encodings (sequential / branch / JAL / JALR)
//   STATUS_*   - bit offsets and width of the tos and count fields in the status word
package lbr_pkg;

    typedef enum logic [1:0] {
        LBR_REQ_NONE   = 2'b00,
        LBR_REQ_FROM   = 2'b01,
        LBR_REQ_TO     = 2'b10,
        LBR_REQ_STATUS = 2'b11
    } lbr_req_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } npc_sel_e;

    localparam int STATUS_TOS_LSB   = 0;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_FIELD_W   = 8;

endpackage

// File: rtl/lbr_ring_buffer.sv
// lbr_ring_buffer: circular FROM/TO record storage with write pointer, saturating count and indexed read
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   wr_en              - store {wr_from, wr_to} at tos and advance the pointer
//   wr_from, wr_to     - source PC and target of the record being stored
//   rd_idx             - age index, 0 is the most recent record
//   rd_from, rd_to     - contents of the indexed slot (combinational)
//   rd_valid           - rd_idx addresses a record that has been written
//   tos, count         - write pointer and number of valid entries
module lbr_ring_buffer
    import lbr_pkg::*;
#(
    parameter int ADDRESS_BITS = 20,
    parameter int LBR_SIZE     = 16,
    localparam int IW          = $clog2(LBR_SIZE),
    localparam int CW          = IW + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDRESS_BITS-1:0] wr_from,
    input  logic [ADDRESS_BITS-1:0] wr_to,
    input  logic [IW-1:0]           rd_idx,
    output logic [ADDRESS_BITS-1:0] rd_from,
    output logic [ADDRESS_BITS-1:0] rd_to,
    output logic                    rd_valid,
    output logic [IW-1:0]           tos,
    output logic [CW-1:0]           count
);

    logic [ADDRESS_BITS-1:0] from_q [LBR_SIZE];
    logic [ADDRESS_BITS-1:0] to_q   [LBR_SIZE];
    logic [IW-1:0]           slot;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LBR_SIZE; i++) begin
                from_q[i] <= '0;
                to_q[i]   <= '0;
            end
            tos   <= '0;
            count <= '0;
        end else if (wr_en) begin
            from_q[tos] <= wr_from;
            to_q[tos]   <= wr_to;
            tos         <= tos + IW'(1);
            count       <= (count == CW'(LBR_SIZE)) ? count : count + CW'(1);
        end
    end

    // tos points at the next free slot, so the newest record sits one behind it;
    // the IW-bit subtraction wraps modulo LBR_SIZE on its own.
    always_comb begin
        slot     = tos - IW'(1) - rd_idx;
        rd_from  = from_q[slot];
        rd_to    = to_q[slot];
        rd_valid = {1'b0, rd_idx} < count;
    end

endmodule

// File: rtl/lbr_record_unit.sv
// lbr_record_unit: memory-stage last branch record unit, logs taken control transfers and serves software reads
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   stall          - pipeline stall, blocks recording
//   lbrReq         - 00 none, 01 read FROM, 10 read TO, 11 read status
//   next_PC_sel    - 00 sequential, 01 branch, 10 JAL, 11 JALR
//   RW_address     - read index in its low log2(LBR_SIZE) bits
//   ALU_result     - bit 0 is the branch-taken flag
//   PC_address     - PC of the control-transfer instruction
//   JAL_target     - target for branch or JAL
//   JALR_target    - target for JALR
//   output_data    - read result, zero while reset is high
// Build option: define LBR_CALL_FILTER_EN to record only JAL/JALR and ignore conditional branches.
module lbr_record_unit
    import lbr_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int LBR_SIZE     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              lbrReq,
    input  logic [1:0]              next_PC_sel,
    input  logic [DATA_WIDTH-1:0]   RW_address,
    input  logic [DATA_WIDTH-1:0]   ALU_result,
    input  logic [ADDRESS_BITS-1:0] PC_address,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    output logic [DATA_WIDTH-1:0]   output_data
);

    localparam int IW = $clog2(LBR_SIZE);
    localparam int CW = IW + 1;

`ifdef LBR_CALL_FILTER_EN
    localparam bit RECORD_BRANCH = 1'b0;
`else
    localparam bit RECORD_BRANCH = 1'b1;
`endif

    logic                    taken;
    logic [ADDRESS_BITS-1:0] target;
    logic [ADDRESS_BITS-1:0] rd_from;
    logic [ADDRESS_BITS-1:0] rd_to;
    logic [ADDRESS_BITS-1:0] rd_word;
    logic                    rd_valid;
    logic [IW-1:0]           tos;
    logic [CW-1:0]           count;
    logic [DATA_WIDTH-1:0]   status;
    logic                    unused_bits;

    assign unused_bits = ^{RW_address[DATA_WIDTH-1:IW], ALU_result[DATA_WIDTH-1:1]};

    always_comb begin
        taken  = (next_PC_sel == NPC_JAL) || (next_PC_sel == NPC_JALR) ||
                 (RECORD_BRANCH && (next_PC_sel == NPC_BRANCH) && ALU_result[0]);
        target = (next_PC_sel == NPC_JALR) ? JALR_target : JAL_target;
    end

    lbr_ring_buffer #(
        .ADDRESS_BITS(ADDRESS_BITS),
        .LBR_SIZE    (LBR_SIZE)
    ) u_ring (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (taken && !stall),
        .wr_from (PC_address),
        .wr_to   (target),
        .rd_idx  (RW_address[IW-1:0]),
        .rd_from (rd_from),
        .rd_to   (rd_to),
        .rd_valid(rd_valid),
        .tos     (tos),
        .count   (count)
    );

    always_comb begin
        status      = (DATA_WIDTH'(count) << STATUS_COUNT_LSB) | (DATA_WIDTH'(tos) << STATUS_TOS_LSB);
        rd_word     = (lbrReq == LBR_REQ_FROM) ? rd_from : rd_to;
        output_data = (reset || lbrReq == LBR_REQ_NONE) ? '0 :
                      (lbrReq == LBR_REQ_STATUS)        ? status :
                      rd_valid                          ? DATA_WIDTH'(rd_word) : '0;
    end

endmodule

// File: tb/tb_lbr_record_unit.sv
// tb_lbr_record_unit: directed and random checks of lbr_record_unit against a history-list model
module tb_lbr_record_unit;

    localparam int DW = 32;
    localparam int AB = 20;
    localparam int N  = 16;

`ifdef LBR_CALL_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic [1:0]    lbrReq;
    logic [1:0]    next_PC_sel;
    logic [DW-1:0] RW_address;
    logic [DW-1:0] ALU_result;
    logic [AB-1:0] PC_address;
    logic [AB-1:0] JAL_target;
    logic [AB-1:0] JALR_target;
    logic [DW-1:0] output_data;

    int errors = 0;
    int checks = 0;

    // history of records, newest first; total counts every record since reset
    logic [AB-1:0] h_from[$];
    logic [AB-1:0] h_to[$];
    int            total = 0;

    lbr_record_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LBR_SIZE(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .lbrReq     (lbrReq),
        .next_PC_sel(next_PC_sel),
        .RW_address (RW_address),
        .ALU_result (ALU_result),
        .PC_address (PC_address),
        .JAL_target (JAL_target),
        .JALR_target(JALR_target),
        .output_data(output_data)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] model_read();
        int idx;
        idx = int'(RW_address % N);
        if (reset || lbrReq == 2'b00) return '0;
        if (lbrReq == 2'b11) return DW'((h_from.size() << 8) | (total % N));
        if (idx >= h_from.size()) return '0;
        return (lbrReq == 2'b01) ? DW'(h_from[idx]) : DW'(h_to[idx]);
    endfunction

    task automatic model_update();
        bit tk;
        tk = next_PC_sel == 2'b10 || next_PC_sel == 2'b11 ||
             (next_PC_sel == 2'b01 && ALU_result[0] && !FILT);
        if (reset) begin
            h_from.delete();
            h_to.delete();
            total = 0;
        end else if (!stall && tk) begin
            h_from.push_front(PC_address);
            h_to.push_front(next_PC_sel == 2'b11 ? JALR_target : JAL_target);
            if (h_from.size() > N) begin
                void'(h_from.pop_back());
                void'(h_to.pop_back());
            end
            total++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic drive(input logic [1:0] sel, input logic [DW-1:0] alu, input logic [AB-1:0] pc,
                         input logic [AB-1:0] jt, input logic [AB-1:0] jrt, input logic st);
        next_PC_sel = sel;
        ALU_result  = alu;
        PC_address  = pc;
        JAL_target  = jt;
        JALR_target = jrt;
        stall       = st;
    endtask

    task automatic rd(input logic [1:0] req, input logic [DW-1:0] addr);
        lbrReq     = req;
        RW_address = addr;
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] exp);
        checks++;
        assert (output_data === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, output_data, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check(tag, model_read());
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b11, '0);
        tick();
        check("status_in_reset", 32'h0);
        drive(2'b10, '0, 20'h00AAA, 20'h00BBB, '0, 1'b0);
        tick();
        reset = 1'b0;
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b11, '0);
        check("status_after_reset", 32'h0);
        rd(2'b01, '0);
        check("from_empty", 32'h0);

        drive(2'b10, '0, 20'h00100, 20'h00200, '0, 1'b0);
        rd(2'b01, '0);
        check("jal_same_cycle_old", 32'h0);
        tick();
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b01, '0);
        check("jal_from", 32'h00000100);
        rd(2'b10, '0);
        check("jal_to", 32'h00000200);
        rd(2'b11, '0);
        check("jal_status", 32'h00000101);

        drive(2'b01, 32'h0, 20'h00300, 20'h00340, '0, 1'b0);
        tick();
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b11, '0);
        check("br_not_taken_status", 32'h00000101);
        drive(2'b01, 32'h1, 20'h00300, 20'h00340, '0, 1'b0);
        tick();
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b01, '0);
        check_model("br_taken_from0");
        rd(2'b10, '0);
        check_model("br_taken_to0");
        rd(2'b01, 32'h1);
        check_model("br_taken_from1");
        rd(2'b11, '0);
        check_model("br_taken_status");

        drive(2'b11, '0, 20'h00400, 20'h00999, 20'h00500, 1'b1);
        tick();
        rd(2'b01, '0);
        check_model("stalled_from0");
        rd(2'b11, '0);
        check_model("stalled_status");
        stall = 1'b0;
        tick();
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b01, '0);
        check("jalr_from", 32'h00000400);
        rd(2'b10, '0);
        check("jalr_to", 32'h00000500);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            drive(2'b10, '0, AB'(32'h1000 + 4 * k), AB'(32'h2000 + k), '0, 1'b0);
            tick();
        end
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b11, '0);
        check("wrap_status", 32'h00001001);
        rd(2'b01, 32'h0);
        check("wrap_from0", 32'h00001040);
        rd(2'b01, 32'hF);
        check("wrap_from15", 32'h00001004);
        rd(2'b10, 32'hFFFF_FFF0);
        check("wrap_to0_hi_addr", 32'h00002010);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), DW'($urandom), AB'($urandom), AB'($urandom), AB'($urandom),
                  $urandom_range(0, 9) == 0);
            rd(2'($urandom), (i % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 3)));
            check_model("random");
            tick();
        end

        drive(2'b10, '0, 20'h0ABCD, 20'h0DCBA, '0, 1'b0);
        rd(2'b01, '0);
        check_model("same_cycle_old");
        tick();
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b01, '0);
        check("same_cycle_new", 32'h0000ABCD);

        drive(2'b11, '0, 20'h01111, '0, 20'h02222, 1'b0);
        reset = 1'b1;
        rd(2'b11, '0);
        check("status_during_reset", 32'h0);
        tick();
        reset = 1'b0;
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        rd(2'b11, '0);
        check("status_post_reset", 32'h0);
        rd(2'b01, '0);
        check("from_post_reset", 32'h0);
        rd(2'b10, 32'h5);
        check("to_post_reset", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lbr_record_unit.md
Name: lbr_record_unit

Overview:
- Last Branch Record unit in the memory stage of the BRISC-V pipeline.
- Records the source PC and target of every taken control transfer in a circular buffer of LBR_SIZE entries.
- Software reads the buffer through lbrReq; the stage bypass mux selects output_data when the instruction is an LBR read.

Parameters:
- DATA_WIDTH, 32: width of RW_address, ALU_result and output_data.
- ADDRESS_BITS, 20: width of PC and target addresses.
- LBR_SIZE, 16: number of record entries; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall; blocks recording while high.
- lbrReq  in  2  read request: 00 none, 01 read FROM, 10 read TO, 11 read status.
- next_PC_sel  in  2  control-transfer type: 00 sequential, 01 conditional branch, 10 JAL, 11 JALR.
- RW_address  in  DATA_WIDTH  read index; low log2(LBR_SIZE) bits are used.
- ALU_result  in  DATA_WIDTH  bit 0 is the branch-taken flag for conditional branches.
- PC_address  in  ADDRESS_BITS  PC of the control-transfer instruction.
- JAL_target  in  ADDRESS_BITS  target for a branch or JAL.
- JALR_target  in  ADDRESS_BITS  target for JALR.
- output_data  out  DATA_WIDTH  read result.

Behaviour:
- State:
  - from[LBR_SIZE] and to[LBR_SIZE], each ADDRESS_BITS wide.
  - tos: write pointer, log2(LBR_SIZE) bits.
  - count: valid entries, 0..LBR_SIZE, saturating.
- Reset (synchronous): all entries, tos and count clear to 0. output_data is 0 while reset is high.
- Taken transfer, defined as:
  - next_PC_sel=10 (JAL), target JAL_target;
  - next_PC_sel=11 (JALR), target JALR_target;
  - next_PC_sel=01 with ALU_result[0]=1, target JAL_target.
- next_PC_sel=00, or 01 with ALU_result[0]=0: nothing is recorded.
- Record, on the rising edge when reset=0, stall=0 and a taken transfer is present:
  - from[tos] <= PC_address; to[tos] <= target;
  - tos <= tos+1, wrapping modulo LBR_SIZE;
  - count <= min(count+1, LBR_SIZE).
- Wrap-around: once full, each new record overwrites the oldest entry. count stays at LBR_SIZE.
- stall=1: no state change. Recording resumes with the inputs present on the first unstalled edge.
- Read path is combinational from registered state (zero-latency) and always reflects pre-edge state.
  - idx = RW_address[log2(LBR_SIZE)-1:0]; idx 0 is the most recent record.
  - Physical slot = (tos-1-idx) mod LBR_SIZE.
  - lbrReq=01: zero-extended from[slot]. lbrReq=10: zero-extended to[slot].
  - If idx >= count, the read returns 0.
  - lbrReq=11: status word {zero pad, count in bits [15:8], tos in bits [7:0]}.
  - lbrReq=00: 0.
- A read and a record in the same cycle: the read returns the old contents; the new record is visible on the next cycle.
- Reset asserted while recording: reset wins; all state clears on that edge.

Optional Feature:
- Macro: LBR_CALL_FILTER_EN.
- Defined: only JAL and JALR are recorded; conditional branches are ignored regardless of ALU_result[0].
- Undefined: all taken transfers are recorded, as described in Behaviour.

Decomposition:
- Package lbr_pkg holds:
  - lbrReq encodings LBR_REQ_NONE, LBR_REQ_FROM, LBR_REQ_TO, LBR_REQ_STATUS;
  - next_PC_sel encodings NPC_SEQ, NPC_BRANCH, NPC_JAL, NPC_JALR;
  - status field offsets.
- One sub-module, lbr_ring_buffer: dual-array storage with write pointer, count and indexed combinational read.
- Top level holds taken/target decode, filtering and the output mux.

Test Plan:
- Reset, then lbrReq=11 -> output_data=0. lbrReq=01 with idx 0 -> 0, since count=0.
- JAL with PC=0x00100, JAL_target=0x00200, stall=0; next cycle:
  - lbrReq=01 idx0 -> 0x00000100;
  - lbrReq=10 idx0 -> 0x00000200;
  - status -> count=1, tos=1.
- Branch PC=0x00300 with ALU_result[0]=0 -> no record, count unchanged. Same with ALU_result[0]=1, target 0x00340 -> recorded at idx0; previous JAL moves to idx1.
- JALR PC=0x00400, JALR_target=0x00500 with stall=1 -> not recorded. Deassert stall -> recorded on that edge.
- 17 JALs with PCs 0x1000+4k, k=0..16, LBR_SIZE=16:
  - count=16, tos=1;
  - idx0 FROM=0x1040;
  - idx15 FROM=0x1004 (0x1000 overwritten).
- Read idx0 in the same cycle as a new JAL -> returns the previous record; the next cycle returns the new one. Assert reset mid-sequence -> all reads return 0 on the following cycle.
